// File: rtl/cve2_pmp_cfg_ctrl_pkg.sv
// Shared types for the PMP CSR controller: region config, mseccfg, scrub FSM states and CSR map.
package cve2_pmp_cfg_ctrl_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } pmp_ctrl_state_e;

    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_MSECCFG   = 12'h747;
    localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

    // Byte layout: L[7], reserved[6:5], A[4:3], X[2], W[1], R[0]; reserved bits are dropped.
    function automatic pmp_cfg_t pmp_byte_to_cfg(input logic [7:0] b);
        pmp_cfg_t c;
        c.lock  = b[7];
        c.mode  = pmp_cfg_mode_e'(b[4:3]);
        c.exec  = b[2];
        c.write = b[1];
        c.read  = b[0];
        return c;
    endfunction

    function automatic logic [7:0] pmp_cfg_to_byte(input pmp_cfg_t c);
        return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
    endfunction

endpackage

// File: rtl/cve2_pmp_cfg_ctrl_if.sv
// CSR write/read port and scrub handshake between the CSR file (master) and the PMP controller (slave).
interface cve2_pmp_cfg_ctrl_if;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_ready_o;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        clear_req_i;
    logic        clear_busy_o;
    logic        clear_done_o;

    modport master (
        output csr_we_i, csr_addr_i, csr_wdata_i, clear_req_i,
        input  csr_ready_o, csr_rdata_o, csr_hit_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  csr_we_i, csr_addr_i, csr_wdata_i, clear_req_i,
        output csr_ready_o, csr_rdata_o, csr_hit_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/cve2_pmp_cfg_legalize.sv
// Per-region pmpcfg byte legalizer: maps a written byte onto the value the region actually stores.
module cve2_pmp_cfg_legalize
    import cve2_pmp_cfg_ctrl_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  pmp_cfg_t    i_old_cfg,
    input  logic [7:0]  i_wbyte,
    input  logic        i_mml,
    output pmp_cfg_t    o_new_cfg
);

    pmp_cfg_t w_cfg;

    always_comb begin
        w_cfg = pmp_byte_to_cfg(i_wbyte);
        // NA4 cannot be expressed once the granule exceeds 4 bytes.
        if (PMPGranularity >= 1 && w_cfg.mode == PMP_MODE_NA4) begin
            w_cfg.mode = PMP_MODE_OFF;
        end
        if (!i_wbyte[0] && i_wbyte[1] && !i_mml) begin
            w_cfg = i_old_cfg;
        end
    end

    assign o_new_cfg = w_cfg;

endmodule

// File: rtl/cve2_pmp_cfg_ctrl.sv
// PMP CSR controller: pmpcfg/pmpaddr/mseccfg storage, lock-aware writes, read rules and scrub FSM.
// Define CVE2_PMP_SMEPMP_EN to implement mseccfg (mml/mmwp/rlb); otherwise it is tied to zero.
module cve2_pmp_cfg_ctrl
    import cve2_pmp_cfg_ctrl_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cve2_pmp_cfg_ctrl_if.slave   bus,
    output pmp_cfg_t             csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]          csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t         csr_pmp_mseccfg_o
);

    localparam int unsigned N = PMPNumRegions;
    localparam logic [31:0] NAPOT_ONES = (PMPGranularity >= 2) ?
                                         ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;
    localparam logic [31:0] TOR_ZEROS  = (PMPGranularity >= 1) ?
                                         ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;

    pmp_cfg_t        r_cfg  [N];
    logic [31:0]     r_addr [N];
    pmp_ctrl_state_e r_state;
    logic [3:0]      r_idx;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic            w_rlb;
    logic            w_mml;
    pmp_mseccfg_t    w_msec;
    logic [N-1:0]    w_locked;
    logic [N-1:0]    w_cfg_we;
    logic [N-1:0]    w_addr_we;
    logic [N-1:0]    w_scrub;
    pmp_cfg_t        w_cfg_new [N];
    pmp_cfg_t        w_cfg_all  [16];
    logic [31:0]     w_addr_all [16];
    logic [31:0]     w_rdata;
    logic            w_wr;
    logic            w_is_cfg;
    logic            w_is_addr;
    logic            w_is_msec;
    logic            w_is_msech;

    assign w_wr       = bus.csr_we_i & r_ready;
    assign w_is_cfg   = bus.csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
    assign w_is_addr  = bus.csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
    assign w_is_msec  = bus.csr_addr_i == CSR_MSECCFG;
    assign w_is_msech = bus.csr_addr_i == CSR_MSECCFGH;

    // The 16-entry views pad unimplemented regions with zero so reads stay uniform.
    for (genvar i = 0; i < 16; i++) begin : g_region
        if (i < N) begin : g_impl
            logic [7:0] w_wbyte;
            assign w_wbyte     = bus.csr_wdata_i[8*(i%4) +: 8];
            assign w_locked[i] = r_cfg[i].lock & ~w_rlb;
            assign w_cfg_we[i] = w_wr & w_is_cfg & (bus.csr_addr_i[1:0] == 2'(i/4)) & ~w_locked[i];
            if (i + 1 < N) begin : g_tor
                assign w_addr_we[i] = w_wr & w_is_addr & (bus.csr_addr_i[3:0] == 4'(i)) & ~w_locked[i]
                                    & ~(w_locked[i+1] & (r_cfg[i+1].mode == PMP_MODE_TOR));
            end else begin : g_last
                assign w_addr_we[i] = w_wr & w_is_addr & (bus.csr_addr_i[3:0] == 4'(i)) & ~w_locked[i];
            end
            assign w_scrub[i] = (r_state == CLEAR) & (r_idx == 4'(i)) & ~w_locked[i];

            cve2_pmp_cfg_legalize #(.PMPGranularity(PMPGranularity)) u_legalize (
                .i_old_cfg (r_cfg[i]),
                .i_wbyte   (w_wbyte),
                .i_mml     (w_mml),
                .o_new_cfg (w_cfg_new[i])
            );

            assign w_cfg_all[i]  = r_cfg[i];
            assign w_addr_all[i] = (r_cfg[i].mode == PMP_MODE_NAPOT) ? (r_addr[i] | NAPOT_ONES) :
                                   r_cfg[i].mode[1]                  ? r_addr[i] :
                                                                       (r_addr[i] & ~TOR_ZEROS);
            assign csr_pmp_cfg_o[i]  = r_cfg[i];
            assign csr_pmp_addr_o[i] = {r_addr[i], 2'b00};
        end else begin : g_none
            assign w_cfg_all[i]  = '0;
            assign w_addr_all[i] = '0;
        end
    end

    // CSR writes only land in IDLE, so they never collide with the scrub clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_cfg_we[i])  r_cfg[i]  <= w_cfg_new[i];
                if (w_addr_we[i]) r_addr[i] <= bus.csr_wdata_i;
                if (w_scrub[i]) begin
                    r_cfg[i]  <= '0;
                    r_addr[i] <= '0;
                end
            end
        end
    end

`ifdef CVE2_PMP_SMEPMP_EN
    pmp_mseccfg_t r_msec;
    logic         w_any_lock;

    always_comb begin
        w_any_lock = 1'b0;
        for (int i = 0; i < N; i++) w_any_lock = w_any_lock | r_cfg[i].lock;
    end

    // mml/mmwp are sticky; rlb may only be raised while nothing is locked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_msec <= '0;
        end else if (w_wr && w_is_msec) begin
            r_msec.mml  <= r_msec.mml  | bus.csr_wdata_i[0];
            r_msec.mmwp <= r_msec.mmwp | bus.csr_wdata_i[1];
            if (r_msec.rlb || !w_any_lock) r_msec.rlb <= bus.csr_wdata_i[2];
        end
    end

    assign w_msec = r_msec;
    assign w_rlb  = r_msec.rlb;
    assign w_mml  = r_msec.mml;
`else
    assign w_msec = '0;
    assign w_rlb  = 1'b0;
    assign w_mml  = 1'b0;
`endif

    assign csr_pmp_mseccfg_o = w_msec;

    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            for (int k = 0; k < 4; k++) begin
                w_rdata[8*k +: 8] = pmp_cfg_to_byte(w_cfg_all[{bus.csr_addr_i[1:0], 2'(k)}]);
            end
        end else if (w_is_addr) begin
            w_rdata = w_addr_all[bus.csr_addr_i[3:0]];
        end else if (w_is_msec) begin
            w_rdata = {29'd0, w_msec};
        end
    end

    assign bus.csr_rdata_o = w_rdata;
    assign bus.csr_hit_o   = w_is_cfg | w_is_addr | w_is_msec | w_is_msech;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.clear_req_i) begin
                    r_state <= CLEAR;
                    r_idx   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
                CLEAR: if (r_idx == 4'(N - 1)) begin
                    r_state <= DONE;
                    r_idx   <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.csr_ready_o  = r_ready;
    assign bus.clear_busy_o = r_busy;
    assign bus.clear_done_o = r_done;

endmodule

// File: tb/tb_cve2_pmp_cfg_ctrl.sv
// Directed bench for cve2_pmp_cfg_ctrl (G=2, 16 regions) with a queue of expected values.
module tb_cve2_pmp_cfg_ctrl;
    import cve2_pmp_cfg_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    pmp_cfg_t     cfg_o  [16];
    logic [33:0]  addr_o [16];
    pmp_mseccfg_t msec_o;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt;
    logic [63:0]  sb [$];
    logic [63:0]  acc;

`ifdef CVE2_PMP_SMEPMP_EN
    localparam logic [31:0] MSEC_EXP = 32'h3;
`else
    localparam logic [31:0] MSEC_EXP = 32'h0;
`endif

    cve2_pmp_cfg_ctrl_if bus();

    cve2_pmp_cfg_ctrl #(.PMPGranularity(2), .PMPNumRegions(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (bus),
        .csr_pmp_cfg_o     (cfg_o),
        .csr_pmp_addr_o    (addr_o),
        .csr_pmp_mseccfg_o (msec_o)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] got);
        logic [63:0] e;
        e = sb.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, e);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.csr_we_i    = 1'b1;
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = d;
        @(posedge clk);
        #1;
        bus.csr_we_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
        expect_v({32'd0, e});
        bus.csr_addr_i = a;
        #1;
        chk(tag, {32'd0, bus.csr_rdata_o});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_clear();
        @(negedge clk);
        bus.clear_req_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.csr_we_i = 1'b0; bus.csr_addr_i = '0; bus.csr_wdata_i = '0; bus.clear_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_v(64'd1); chk("rst_ready", {63'd0, bus.csr_ready_o});
        expect_v(64'd0); chk("rst_busy",  {63'd0, bus.clear_busy_o});
        expect_v(64'd0); chk("rst_done",  {63'd0, bus.clear_done_o});
        expect_v(64'd0); chk("rst_cfg_o", {58'd0, cfg_o[0]});
        expect_v(64'd0); chk("rst_msec",  {61'd0, msec_o});
        rd(12'h3A0, 32'h0, "rst_cfg0");
        rd(12'h3B0, 32'h0, "rst_addr0");

        bus.csr_addr_i = 12'h3A3; expect_v(64'd1); #1 chk("hit_cfg3",  {63'd0, bus.csr_hit_o});
        bus.csr_addr_i = 12'h3BF; expect_v(64'd1); #1 chk("hit_addr15", {63'd0, bus.csr_hit_o});
        bus.csr_addr_i = 12'h757; expect_v(64'd1); #1 chk("hit_msech", {63'd0, bus.csr_hit_o});
        bus.csr_addr_i = 12'h3C0; expect_v(64'd0); #1 chk("hit_none",  {63'd0, bus.csr_hit_o});

        wr(12'h3A0, 32'h0000_1F0F);
        rd(12'h3A0, 32'h0000_1F0F, "cfg_tor_napot");
        expect_v(64'(PMP_MODE_NAPOT)); chk("cfg1_mode_o", 64'(cfg_o[1].mode));
        wr(12'h3A0, 32'h0000_1F02);
        rd(12'h3A0, 32'h0000_1F0F, "cfg_rw01_ign");
        wr(12'h3A1, 32'h0000_1767);
        rd(12'h3A1, 32'h0000_0707, "cfg_legal");

        wr(12'h3A0, 32'h1F00_1F0F);
        wr(12'h3B3, 32'h1000_0000);
        rd(12'h3B3, 32'h1000_0001, "addr_napot");
        expect_v(64'h0_4000_0000); chk("addr3_o", {30'd0, addr_o[3]});
        wr(12'h3A0, 32'h0F00_1F0F);
        rd(12'h3B3, 32'h1000_0000, "addr_tor");
        wr(12'h3B3, 32'h1000_0003);
        rd(12'h3B3, 32'h1000_0000, "addr_tor_mask");
        expect_v(64'h0_4000_000C); chk("addr3_raw", {30'd0, addr_o[3]});

        wr(12'h3A0, 32'h0F00_880F);
        rd(12'h3A0, 32'h0F00_880F, "cfg_lock");
        wr(12'h3B0, 32'h0000_1234);
        rd(12'h3B0, 32'h0, "addr_tor_lock");
        wr(12'h3B1, 32'h0000_0055);
        rd(12'h3B1, 32'h0, "addr_lock");
        wr(12'h3A0, 32'h0F00_000F);
        rd(12'h3A0, 32'h0F00_880F, "cfg_lock_ign");
        wr(12'h747, 32'h7);
        rd(12'h747, MSEC_EXP, "mseccfg");
        rd(12'h757, 32'h0, "mseccfgh");

        // Scrub with regions 2 and 5 locked.
        do_reset();
        for (int i = 0; i < 8; i++) wr(12'h3B0 + 12'(i), 32'h100 + 32'(4 * i));
        wr(12'h3A0, 32'h0F8F_0F0F);
        wr(12'h3A1, 32'h0F0F_8F0F);
        start_clear();
        done_cnt = 0;
        for (int s = 0; s < 18; s++) begin
            expect_v({63'd0, s < 17});  chk("scrub_busy", {63'd0, bus.clear_busy_o});
            expect_v({63'd0, s == 16}); chk("scrub_done", {63'd0, bus.clear_done_o});
            if (bus.clear_done_o) done_cnt++;
            if (s == 3) begin
                expect_v(64'd0); chk("busy_ready", {63'd0, bus.csr_ready_o});
                bus.csr_we_i = 1'b1; bus.csr_addr_i = 12'h3B0; bus.csr_wdata_i = 32'hDEAD_0000;
            end else begin
                bus.csr_we_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.csr_we_i = 1'b0;
        expect_v(64'd1); chk("done_once", 64'(done_cnt));
        rd(12'h3A0, 32'h008F_0000, "scrub_cfg0");
        rd(12'h3A1, 32'h0000_8F00, "scrub_cfg1");
        rd(12'h3A2, 32'h0, "scrub_cfg2");
        rd(12'h3B0, 32'h0, "scrub_addr0");
        rd(12'h3B2, 32'h108, "scrub_addr2");
        rd(12'h3B5, 32'h114, "scrub_addr5");
        rd(12'h3B7, 32'h0, "scrub_addr7");
        expect_v(64'h420); chk("addr2_o", {30'd0, addr_o[2]});

        // Reset during the fourth CLEAR cycle.
        wr(12'h3B7, 32'h77);
        wr(12'h3B0, 32'hA0);
        start_clear();
        repeat (3) begin @(posedge clk); #1; end
        expect_v(64'd1); chk("mid_busy", {63'd0, bus.clear_busy_o});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_v(64'd0); chk("abort_busy",  {63'd0, bus.clear_busy_o});
        expect_v(64'd1); chk("abort_ready", {63'd0, bus.csr_ready_o});
        expect_v(64'd0); chk("abort_done",  {63'd0, bus.clear_done_o});
        acc = {61'd0, msec_o};
        for (int i = 0; i < 16; i++) acc = acc | {58'd0, cfg_o[i]} | {30'd0, addr_o[i]};
        expect_v(64'd0); chk("abort_outs", acc);
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.clear_done_o) done_cnt++;
        end
        expect_v(64'd0); chk("abort_no_done", 64'(done_cnt));
        expect_v(64'd0); chk("abort_busy_late", {63'd0, bus.clear_busy_o});

`ifdef CVE2_PMP_SMEPMP_EN
        wr(12'h747, 32'h4);
        rd(12'h747, 32'h4, "rlb_set");
        wr(12'h3A0, 32'h0000_8800);
        wr(12'h3B0, 32'h0000_1234);
        rd(12'h3B0, 32'h0000_1234, "rlb_addr");
        wr(12'h3A0, 32'h0);
        rd(12'h3A0, 32'h0, "rlb_cfg");
        wr(12'h747, 32'h1);
        rd(12'h747, 32'h1, "mml_set");
        wr(12'h3A0, 32'h0000_0002);
        rd(12'h3A0, 32'h0000_0002, "mml_rw01");
`else
        wr(12'h747, 32'h4);
        rd(12'h747, 32'h0, "msec_tied");
        expect_v(64'd0); chk("msec_o_tied", {61'd0, msec_o});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
